// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the branch resolution slice.
//   word_t        : 32-bit machine word
//   bp_index_t    : predictor table index
//   bp_inflight_t : one predicted branch waiting for the execute stage to resolve it
//   bres_state_t  : branch resolve controller FSM state
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  bp_index_t;

  typedef struct packed {
    logic      taken;
    bp_index_t index;
    word_t     target;
    word_t     npc;
  } bp_inflight_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bres_state_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order FIFO of predicted branches that are still waiting to be resolved.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : synchronous clear (squash everything); wins over push/pop
//   push, din    : enqueue one entry
//   pop          : dequeue the head
//   dout         : head entry (only meaningful when !empty)
//   empty, full  : occupancy flags
module bp_inflight_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  bp_inflight_t din,
  input  logic         pop,
  output bp_inflight_t dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bp_inflight_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: tracks predicted branches from fetch until execute
// resolves them, detects mispredictions, flushes/redirects, and emits a
// registered one-cycle predictor update per accepted resolution.
// Optional macro: BRANCH_STATS_EN adds stat_resolved / stat_mispred counters.
// Ports:
//   CLK, nRST                      : clock, synchronous active-low reset
//   pred_*                         : fetch-side prediction push
//   res_valid/res_taken/res_target : execute-side resolution of the oldest branch
//   fetch_stall                    : FIFO full
//   flush, redirect_en/redirect_pc : mispredict recovery
//   upd_*                          : registered predictor table update
//   res_err                        : sticky, resolution seen with nothing in flight
module branch_resolve_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [3:0]  pred_index,
  input  logic [31:0] pred_target,
  input  logic [31:0] pred_npc,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        fetch_stall,
  output logic        flush,
  output logic        redirect_en,
  output logic [31:0] redirect_pc,
  output logic        upd_en,
  output logic [3:0]  upd_index,
  output logic        upd_taken,
  output logic [31:0] upd_target,
  output logic        res_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  bres_state_t    state;
  logic [FCW-1:0] flush_cnt;
  bp_inflight_t   head, din;
  logic           empty, full;
  logic           run, res_ok, mispredict, push;

  // Combinational outputs are gated with nRST so everything reads 0 while in reset.
  assign run        = nRST && (state == RUN);
  assign res_ok     = run && res_valid && !empty;
  assign mispredict = res_ok &&
                      ((res_taken != head.taken) || (res_taken && (res_target != head.target)));
  // A mispredict squashes everything younger, including a branch arriving this cycle.
  assign push       = run && pred_valid && !full && !mispredict;

  assign din = '{taken: pred_taken, index: pred_index, target: pred_target, npc: pred_npc};

  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (mispredict),   // pop of the head plus clear of the younger entries
    .push  (push),
    .din   (din),
    .pop   (res_ok),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  assign fetch_stall = nRST && full;
  assign flush       = mispredict || (nRST && (state == FLUSH));
  assign redirect_en = mispredict;
  assign redirect_pc = !mispredict ? '0 : (res_taken ? res_target : head.npc);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= RUN;
      flush_cnt  <= '0;
      upd_en     <= 1'b0;
      upd_index  <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
      res_err    <= 1'b0;
    end else begin
      upd_en <= res_ok;
      if (res_ok) begin
        upd_index  <= head.index;
        upd_taken  <= res_taken;
        upd_target <= res_target;
      end
      if (run && res_valid && empty) res_err <= 1'b1;

      case (state)
        RUN: if (mispredict) begin
          flush_cnt <= FCW'(FLUSH_CYCLES - 1);
          // A single-cycle flush is covered entirely by the mispredict cycle.
          state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
        FLUSH: begin
          if (flush_cnt <= FCW'(1)) begin
            flush_cnt <= '0;
            state     <= RUN;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_ok && (stat_resolved != '1))    stat_resolved <= stat_resolved + 32'd1;
      if (mispredict && (stat_mispred != '1)) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pred_valid, pred_taken;
  logic [3:0]  pred_index;
  logic [31:0] pred_target, pred_npc;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        fetch_stall, flush, redirect_en;
  logic [31:0] redirect_pc;
  logic        upd_en, upd_taken;
  logic [3:0]  upd_index;
  logic [31:0] upd_target;
  logic        res_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  idx;
    logic        taken;
    logic [31:0] tgt;
  } upd_t;
  upd_t sb[$];

  always #5 CLK = ~CLK;

  branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
    .pred_target(pred_target), .pred_npc(pred_npc),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .fetch_stall(fetch_stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
    .res_err(res_err)
`ifdef BRANCH_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every update strobe must match the oldest expected resolution.
  always @(negedge CLK) begin
    if (upd_en === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_upd: observed idx %0h expected no update", upd_index);
      end
      if (sb.size() != 0) begin
        upd_t e;
        e = sb.pop_front();
        chk("sb_upd_index", 32'(upd_index), 32'(e.idx));
        chk("sb_upd_taken", 32'(upd_taken), 32'(e.taken));
        chk("sb_upd_target", upd_target, e.tgt);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle();
    pred_valid = 0; pred_taken = 0; pred_index = 0; pred_target = 0; pred_npc = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
  endtask

  task automatic drive_pred(input logic t, input logic [3:0] idx,
                            input logic [31:0] tgt, input logic [31:0] npc);
    pred_valid = 1; pred_taken = t; pred_index = idx; pred_target = tgt; pred_npc = npc;
  endtask

  task automatic drive_res(input logic t, input logic [31:0] tgt);
    res_valid = 1; res_taken = t; res_target = tgt;
  endtask

  function automatic upd_t mk(input logic [3:0] i, input logic t, input logic [31:0] g);
    upd_t u;
    u.idx = i; u.taken = t; u.tgt = g;
    return u;
  endfunction

`ifdef BRANCH_STATS_EN
  task automatic one_branch(input logic [3:0] idx, input logic pt, input logic [31:0] ptgt,
                            input logic rt, input logic [31:0] rtgt);
    idle(); drive_pred(pt, idx, ptgt, 32'h200); tick();
    idle(); drive_res(rt, rtgt); sb.push_back(mk(idx, rt, rtgt)); tick();
    idle(); tick(); tick();
  endtask
`endif

  initial begin
    idle();
    nRST = 0;
    repeat (2) tick();
    chk("rst_fetch_stall", 32'(fetch_stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redirect_en", 32'(redirect_en), 0);
    chk("rst_upd_en", 32'(upd_en), 0);
    chk("rst_res_err", 32'(res_err), 0);
    nRST = 1;

    // 1: correct taken prediction
    drive_pred(1, 4'd3, 32'h40, 32'h14); tick();
    idle(); drive_res(1, 32'h40); #1;
    chk("t1_flush", 32'(flush), 0);
    chk("t1_redirect_en", 32'(redirect_en), 0);
    sb.push_back(mk(4'd3, 1, 32'h40));
    tick(); idle(); #1;
    chk("t1_upd_en", 32'(upd_en), 1);
    chk("t1_upd_index", 32'(upd_index), 3);
    tick();
    chk("t1_upd_en_drop", 32'(upd_en), 0);

    // 2: predicted not-taken, actually taken
    drive_pred(0, 4'd5, 32'h99, 32'h24); tick();
    idle(); drive_res(1, 32'h80); #1;
    chk("t2_flush", 32'(flush), 1);
    chk("t2_redirect_en", 32'(redirect_en), 1);
    chk("t2_redirect_pc", redirect_pc, 32'h80);
    sb.push_back(mk(4'd5, 1, 32'h80));
    tick(); idle();
    res_valid = 1;   // must be ignored while flushing: no res_err
    #1;
    chk("t2_flush_hold", 32'(flush), 1);
    chk("t2_redirect_off", 32'(redirect_en), 0);
    chk("t2_upd_taken", 32'(upd_taken), 1);
    tick(); idle(); #1;
    chk("t2_flush_done", 32'(flush), 0);
    chk("t2_no_res_err", 32'(res_err), 0);

    // 3: predicted taken, actually not taken; younger entries squashed
    drive_pred(1, 4'd1, 32'h100, 32'h30); tick();
    drive_pred(0, 4'd2, 32'h0, 32'h34); tick();
    drive_pred(0, 4'd4, 32'h0, 32'h38); tick();
    drive_pred(0, 4'd12, 32'h0, 32'h3c);   // same cycle as mispredict: dropped
    drive_res(0, 32'h200); #1;
    chk("t3_flush", 32'(flush), 1);
    chk("t3_redirect_pc", redirect_pc, 32'h30);
    sb.push_back(mk(4'd1, 0, 32'h200));
    tick(); idle(); tick(); #1;
    chk("t3_flush_done", 32'(flush), 0);

    // 4: fill to full, stall, then drain with a concurrent push+pop
    drive_pred(0, 4'd6, 32'h0, 32'h50); tick();
    drive_pred(0, 4'd7, 32'h0, 32'h54); tick();
    drive_pred(0, 4'd8, 32'h0, 32'h58); tick(); #1;
    chk("t4_not_full_at_3", 32'(fetch_stall), 0);
    drive_pred(0, 4'd9, 32'h0, 32'h5c); tick(); #1;
    chk("t4_full", 32'(fetch_stall), 1);
    drive_pred(0, 4'd10, 32'h0, 32'h60); tick();   // blocked by stall
    idle(); drive_res(0, 32'h6); #1;
    chk("t4_stall_until_pop", 32'(fetch_stall), 1);
    sb.push_back(mk(4'd6, 0, 32'h6));
    tick(); idle(); #1;
    chk("t4_stall_release", 32'(fetch_stall), 0);
    drive_pred(0, 4'd11, 32'h0, 32'h64); drive_res(0, 32'h7);
    sb.push_back(mk(4'd7, 0, 32'h7)); tick();
    idle(); drive_res(0, 32'h8); sb.push_back(mk(4'd8, 0, 32'h8)); tick();
    drive_res(0, 32'h9);  sb.push_back(mk(4'd9, 0, 32'h9));  tick();
    drive_res(0, 32'hb);  sb.push_back(mk(4'd11, 0, 32'hb)); tick();

    // 5: resolution with nothing in flight
    drive_res(1, 32'h123); tick();
    idle(); #1;
    chk("t5_res_err", 32'(res_err), 1);
    chk("t5_no_upd", 32'(upd_en), 0);
    tick();
    chk("t5_res_err_sticky", 32'(res_err), 1);
    nRST = 0; tick(); #1;
    chk("t5_res_err_clear", 32'(res_err), 0);
    nRST = 1;

    // Reset while flushing
    drive_pred(0, 4'd13, 32'h0, 32'h70); tick();
    idle(); drive_res(1, 32'h60); #1;
    chk("rf_redirect_pc", redirect_pc, 32'h60);
    sb.push_back(mk(4'd13, 1, 32'h60));
    tick(); idle(); nRST = 0; #1;
    chk("rf_flush_in_reset", 32'(flush), 0);
    tick(); nRST = 1; #1;
    chk("rf_flush_after", 32'(flush), 0);
    chk("rf_stall_after", 32'(fetch_stall), 0);
    chk("rf_upd_after", 32'(upd_en), 0);

`ifdef BRANCH_STATS_EN
    nRST = 0; tick(); nRST = 1;
    one_branch(4'd1, 1, 32'h10, 1, 32'h10);
    one_branch(4'd2, 0, 32'h0,  1, 32'h20);   // mispredict
    one_branch(4'd3, 0, 32'h0,  0, 32'h30);
    one_branch(4'd4, 1, 32'h40, 1, 32'h44);   // mispredict (target)
    one_branch(4'd5, 1, 32'h50, 1, 32'h50);
    chk("stat_resolved", stat_resolved, 5);
    chk("stat_mispred", stat_mispred, 2);
`endif

    idle(); repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
